// File: rtl/spi_erisim_hakemi.sv
// Two-requester arbiter into an AXI-Lite style SPI register window.
// One transaction in flight; bad requests are answered locally with an error.
module spi_erisim_hakemi #(
  parameter logic [31:0] SPI_BASE_ADDR = 32'h2001_0000,
  parameter logic [31:0] SPI_MASK_ADDR = 32'h0000_00ff,
  parameter logic [15:0] ZAMAN_ASIMI   = 16'd1024
) (
  input  logic        s_axi_aclk_i,
  input  logic        s_axi_aresetn_i,
  input  logic [1:0]  istek_gecerli_i,
  input  logic [1:0]  istek_yaz_i,
  input  logic [63:0] istek_adres_i,
  input  logic [63:0] istek_veri_i,
  input  logic [3:0]  istek_boyut_i,
  output logic [1:0]  istek_hazir_o,
  output logic [1:0]  cevap_gecerli_o,
  output logic [31:0] cevap_veri_o,
  output logic        cevap_hata_o,
  output logic [31:0] m_axi_araddr_o,
  output logic        m_axi_arvalid_o,
  input  logic        m_axi_arready_i,
  input  logic        m_axi_rvalid_i,
  output logic        m_axi_rready_o,
  input  logic [31:0] m_axi_rdata_i,
  input  logic        m_axi_rresp_i,
  output logic [31:0] m_axi_awaddr_o,
  output logic        m_axi_awvalid_o,
  input  logic        m_axi_awready_i,
  output logic [31:0] m_axi_wdata_o,
  output logic [3:0]  m_axi_wstrb_o,
  output logic        m_axi_wvalid_o,
  input  logic        m_axi_wready_i,
  input  logic        m_axi_bvalid_i,
  output logic        m_axi_bready_o,
  input  logic        m_axi_bresp_i,
  output logic [3:0]  okuma_boyut_o
);

  typedef enum logic [1:0] {BOSTA, ADRES, YANIT, CEVAP} durum_e;

  durum_e      durum_q, durum_d;
  logic        sahip_q, sahip_d;
  logic        son_q, son_d;
  logic        yaz_q, yaz_d;
  logic        hata_q, hata_d;
  logic        aw_bitti_q, aw_bitti_d;
  logic        w_bitti_q, w_bitti_d;
  logic [31:0] adres_q, adres_d;
  logic [31:0] veri_q, veri_d;
  logic [31:0] cevap_veri_q, cevap_veri_d;
  logic [1:0]  boyut_q, boyut_d;
  logic [15:0] sayac_q, sayac_d;

  logic        sec, hizali, gecersiz, zaman_doldu;
  logic [1:0]  hibe, sec_boyut;
  logic [31:0] sec_adres;
  logic        okuma_faz, yazma_faz, aw_ok, w_ok;
  logic [3:0]  maske;

  // Tie goes to the requester not granted last; son_q resets to 1 so requester 0 wins first.
  always_comb begin
    sec       = (&istek_gecerli_i) ? ~son_q : istek_gecerli_i[1];
    sec_adres = sec ? istek_adres_i[63:32] : istek_adres_i[31:0];
    sec_boyut = sec ? istek_boyut_i[3:2]   : istek_boyut_i[1:0];
    case (sec_boyut)
      2'b00:   hizali = 1'b1;
      2'b01:   hizali = ~sec_adres[0];
      2'b10:   hizali = (sec_adres[1:0] == 2'b00);
      default: hizali = 1'b0;
    endcase
    gecersiz = ((sec_adres & ~SPI_MASK_ADDR) != SPI_BASE_ADDR) || !hizali;
    hibe = 2'b00;
    if (durum_q == BOSTA && (|istek_gecerli_i) && !s_axi_aresetn_i)
      hibe = sec ? 2'b10 : 2'b01;
  end

  always_comb begin
    case (boyut_q)
      2'b00:   maske = 4'b0001;
      2'b01:   maske = 4'b0011;
      2'b10:   maske = 4'b1111;
      default: maske = 4'b0000;
    endcase
  end

  assign okuma_faz   = (durum_q == ADRES) && !yaz_q;
  assign yazma_faz   = (durum_q == ADRES) && yaz_q;
  assign zaman_doldu = (sayac_q == ZAMAN_ASIMI - 16'd1);

  assign m_axi_arvalid_o = okuma_faz;
  assign m_axi_araddr_o  = okuma_faz ? adres_q : 32'd0;
  assign okuma_boyut_o   = okuma_faz ? maske : 4'd0;
  assign m_axi_awvalid_o = yazma_faz && !aw_bitti_q;
  assign m_axi_wvalid_o  = yazma_faz && !w_bitti_q;
  assign m_axi_awaddr_o  = yazma_faz ? adres_q : 32'd0;
  assign m_axi_wdata_o   = yazma_faz ? veri_q : 32'd0;
  assign m_axi_wstrb_o   = yazma_faz ? maske : 4'd0;
  assign m_axi_rready_o  = (durum_q == YANIT) && !yaz_q;
  assign m_axi_bready_o  = (durum_q == YANIT) && yaz_q;

  assign aw_ok = aw_bitti_q || (m_axi_awvalid_o && m_axi_awready_i);
  assign w_ok  = w_bitti_q  || (m_axi_wvalid_o && m_axi_wready_i);

  assign istek_hazir_o   = hibe;
  assign cevap_gecerli_o = (durum_q == CEVAP) ? (sahip_q ? 2'b10 : 2'b01) : 2'b00;
  assign cevap_hata_o    = (durum_q == CEVAP) && hata_q;
  assign cevap_veri_o    = cevap_veri_q;

  always_comb begin
    durum_d      = durum_q;
    sahip_d      = sahip_q;
    son_d        = son_q;
    yaz_d        = yaz_q;
    hata_d       = hata_q;
    aw_bitti_d   = aw_bitti_q;
    w_bitti_d    = w_bitti_q;
    adres_d      = adres_q;
    veri_d       = veri_q;
    cevap_veri_d = cevap_veri_q;
    boyut_d      = boyut_q;
    sayac_d      = sayac_q;
    case (durum_q)
      BOSTA: begin
        sayac_d    = 16'd0;
        aw_bitti_d = 1'b0;
        w_bitti_d  = 1'b0;
        if (|hibe) begin
          sahip_d = sec;
          son_d   = sec;
          yaz_d   = istek_yaz_i[sec];
          adres_d = sec_adres;
          veri_d  = sec ? istek_veri_i[63:32] : istek_veri_i[31:0];
          boyut_d = sec_boyut;
          hata_d  = gecersiz;
          durum_d = gecersiz ? CEVAP : ADRES;
        end
      end
      ADRES: begin
        sayac_d = sayac_q + 16'd1;
        if (zaman_doldu) begin
          hata_d  = 1'b1;
          durum_d = CEVAP;
        end else if (!yaz_q) begin
          if (m_axi_arready_i) durum_d = YANIT;
        end else begin
          aw_bitti_d = aw_ok;
          w_bitti_d  = w_ok;
          if (aw_ok && w_ok) durum_d = YANIT;
        end
      end
      YANIT: begin
        sayac_d = sayac_q + 16'd1;
        if (zaman_doldu) begin
          hata_d  = 1'b1;
          durum_d = CEVAP;
        end else if (yaz_q && m_axi_bvalid_i) begin
          hata_d  = ~m_axi_bresp_i;
          durum_d = CEVAP;
        end else if (!yaz_q && m_axi_rvalid_i) begin
          cevap_veri_d = m_axi_rdata_i;
          hata_d       = ~m_axi_rresp_i;
          durum_d      = CEVAP;
        end
      end
      default: durum_d = BOSTA;
    endcase
  end

  always_ff @(posedge s_axi_aclk_i or posedge s_axi_aresetn_i) begin
    if (s_axi_aresetn_i) begin
      durum_q      <= BOSTA;
      sahip_q      <= 1'b0;
      son_q        <= 1'b1;
      yaz_q        <= 1'b0;
      hata_q       <= 1'b0;
      aw_bitti_q   <= 1'b0;
      w_bitti_q    <= 1'b0;
      adres_q      <= 32'd0;
      veri_q       <= 32'd0;
      cevap_veri_q <= 32'd0;
      boyut_q      <= 2'd0;
      sayac_q      <= 16'd0;
    end else begin
      durum_q      <= durum_d;
      sahip_q      <= sahip_d;
      son_q        <= son_d;
      yaz_q        <= yaz_d;
      hata_q       <= hata_d;
      aw_bitti_q   <= aw_bitti_d;
      w_bitti_q    <= w_bitti_d;
      adres_q      <= adres_d;
      veri_q       <= veri_d;
      cevap_veri_q <= cevap_veri_d;
      boyut_q      <= boyut_d;
      sayac_q      <= sayac_d;
    end
  end

endmodule

// File: doc/spi_erisim_hakemi.md
SPI_ERISIM_HAKEMI -- requirements
Module: spi_erisim_hakemi

Interface
REQ-001 SHALL have parameter SPI_BASE_ADDR, 32'h2001_0000, base of SPI register window.
REQ-002 SHALL have parameter SPI_MASK_ADDR, 32'h0000_00ff, offset bits inside window.
REQ-003 SHALL have parameter ZAMAN_ASIMI, 16'd1024, max cycles from AXI issue to response.
REQ-004 SHALL have ports (name  direction  width  meaning):
 s_axi_aclk_i  in  1  single clock, rising edge
 s_axi_aresetn_i  in  1  reset, asynchronous, active-high
 istek_gecerli_i  in  2  request valid per requester (bit0 = core LSU, bit1 = second master)
 istek_yaz_i  in  2  1 = write, 0 = read, per requester
 istek_adres_i  in  64  address; requester k in bits [32k+31:32k]
 istek_veri_i  in  64  write data; requester k in bits [32k+31:32k]
 istek_boyut_i  in  4  size per requester: 00 byte, 01 half, 10 word, 11 illegal
 istek_hazir_o  out  2  one-cycle accept pulse, one-hot
 cevap_gecerli_o  out  2  one-cycle response pulse, one-hot, to owning requester
 cevap_veri_o  out  32  read data of last response
 cevap_hata_o  out  1  error flag, qualified by cevap_gecerli_o
 m_axi_araddr_o  out  32  read address
 m_axi_arvalid_o  out  1  read address valid
 m_axi_arready_i  in  1  read address ready
 m_axi_rvalid_i  in  1  read data valid
 m_axi_rready_o  out  1  read data ready
 m_axi_rdata_i  in  32  read data
 m_axi_rresp_i  in  1  1 = okay, 0 = fail
 m_axi_awaddr_o  out  32  write address
 m_axi_awvalid_o  out  1  write address valid
 m_axi_awready_i  in  1  write address ready
 m_axi_wdata_o  out  32  write data
 m_axi_wstrb_o  out  4  write strobe
 m_axi_wvalid_o  out  1  write data valid
 m_axi_wready_i  in  1  write data ready
 m_axi_bvalid_i  in  1  write response valid
 m_axi_bready_o  out  1  write response ready
 m_axi_bresp_i  in  1  1 = okay, 0 = fail
 okuma_boyut_o  out  4  read size to SPI slave: 0001 byte, 0011 half, 1111 word

Function
REQ-005 SHALL implement FSM BOSTA -> ADRES -> YANIT -> CEVAP -> BOSTA; one transaction outstanding max.
REQ-006 In BOSTA with any istek_gecerli_i set, SHALL grant round-robin (requester not granted last wins ties), pulse istek_hazir_o[k], register request, enter ADRES next cycle.
REQ-007 Request SHALL be rejected (no AXI traffic, BOSTA -> CEVAP with cevap_hata_o=1) if address outside window ((addr & ~SPI_MASK_ADDR) != SPI_BASE_ADDR), size 11, or misaligned (half: addr[0]=1; word: addr[1:0]!=0).
REQ-008 Read in ADRES: arvalid=1, araddr and okuma_boyut_o stable until arready sampled 1; then YANIT with rready=1.
REQ-009 Write in ADRES: awvalid and wvalid raised together, each dropped individually after its ready; YANIT entered when both handshakes done; bready=1 in YANIT.
REQ-010 wstrb SHALL be 0001/0011/1111 for byte/half/word; wdata passed unshifted.
REQ-011 In YANIT on rvalid (read) or bvalid (write): capture rdata into cevap_veri_o, cevap_hata_o = ~resp, enter CEVAP.
REQ-012 CEVAP SHALL last one cycle: cevap_gecerli_o[owner]=1; cevap_veri_o holds until next read response.
REQ-013 16-bit timeout counter SHALL clear on leaving BOSTA, count in ADRES/YANIT; on reaching ZAMAN_ASIMI deassert all AXI valids/readies, enter CEVAP with cevap_hata_o=1.
REQ-014 Minimum turnaround accepted-to-response: 3 cycles with zero-wait slave; no grant while not BOSTA.

Reset
REQ-015 Reset SHALL asynchronously force BOSTA, all outputs 0, counter 0, round-robin pointer favouring requester 0.
REQ-016 Reset mid-transaction SHALL drop AXI valids immediately; abandoned transaction produces no response.

Verification
REQ-017 Both requesters read 0x2001_0004 word same cycle after reset -> requester 0 granted first, then 1; two cevap pulses, rdata returned.
REQ-018 Write byte 0x2001_0010, data 0xA5 -> wstrb 0001, aw/w handshake, bresp=1 -> cevap_gecerli_o=01, hata=0.
REQ-019 Read 0x2002_0000 or half at 0x2001_0001 -> no arvalid, cevap_hata_o=1 one cycle after accept.
REQ-020 Slave withholds rvalid -> response with hata=1 exactly ZAMAN_ASIMI cycles after entering ADRES.
REQ-021 awready before wready by 3 cycles -> awvalid drops after its handshake, wvalid held until wready.
REQ-022 Reset asserted while in YANIT -> all outputs 0 same cycle, no cevap pulse afterwards.
